led_strip_tx: RTL and testbench
===============================

LED_STRIP_TX -- requirements
Module: led_strip_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter LED_COUNT, 8, number of chained LEDs (1..64), 3 bytes each.
REQ-003 SHALL have parameter T0H_NS, 300, high time of a '0' bit in ns.
REQ-004 SHALL have parameter T1H_NS, 800, high time of a '1' bit in ns.
REQ-005 SHALL have parameter TBIT_NS, 1250, total bit period in ns.
REQ-006 SHALL have parameter TRST_US, 80, low latch gap after the frame in us.
REQ-007 SHALL have parameter ADDR_W, 8, register address width; must satisfy 2**ADDR_W > 3*LED_COUNT.
REQ-008 SHALL have port i_clk input 1: the single clock; all logic on rising edge.
REQ-009 SHALL have port i_rst_n input 1: reset, asynchronous, active-low.
REQ-010 SHALL have port i_wr_n input 1: active-low write strobe, one write per cycle low.
REQ-011 SHALL have port i_addr input ADDR_W: byte address.
REQ-012 SHALL have port i_data input 8: write data.
REQ-013 SHALL have port o_data output 8: combinational read of the byte at i_addr.
REQ-014 SHALL have port o_busy output 1: frame or latch gap in progress.
REQ-015 SHALL have port o_done output 1: one-cycle pulse at frame completion.
REQ-016 SHALL have port o_sk output 1: serial line to the first LED.

Function
REQ-017 SHALL map addresses 0..3*LED_COUNT-1 to the colour bytes, three per LED in G,R,B order, LED 0 at address 0.
REQ-018 SHALL treat address CTRL=3*LED_COUNT as control: writing bit0=1 starts a frame; o_data at CTRL = {7'b0, o_busy}; other addresses read 0, and writes to them are ignored.
REQ-019 SHALL derive cycle counts as floor(CLK_HZ*ns/1e9): at defaults TBIT=62, T0H=15, T1H=40, TRST=4000 cycles.
REQ-020 SHALL run FSM IDLE -> LOAD -> HIGH -> LOW -> (LOAD or LATCH) -> IDLE.
REQ-021 SHALL, in LOAD (1 cycle), fetch the next byte, MSB first, from address 0 upward.
REQ-022 SHALL hold o_sk=1 in HIGH for T0H or T1H cycles per bit value, then o_sk=0 in LOW until TBIT cycles from the bit's start.
REQ-023 SHALL go from the last bit of a byte to LOAD with no gap: LOAD is absorbed into the previous LOW so every bit period is exactly TBIT cycles.
REQ-024 SHALL enter LATCH after bit 24*LED_COUNT, hold o_sk=0 for TRST cycles, then return to IDLE with o_done=1 for that one cycle.
REQ-025 SHALL assert o_busy the cycle after the start write, deasserting it the same cycle o_done pulses; o_sk first rises 2 cycles after the start-write edge.
REQ-026 SHALL ignore colour and start writes while o_busy=1; frame data is never torn.
REQ-027 SHALL accept a start write on the cycle o_done pulses, entering LOAD next cycle.
REQ-028 SHALL use a bit counter wide enough for 24*LED_COUNT with no wrap; the bit-time counter never exceeds TBIT-1.

Reset
REQ-029 SHALL on i_rst_n=0 immediately force o_sk=0, o_busy=0, o_done=0, FSM=IDLE, counters=0 and all colour bytes=0, including mid-frame.
REQ-030 SHALL require a fresh start write after reset release; no frame auto-starts.

Structure
REQ-031 SHALL place FSM state encodings and the ns/us-to-cycle conversion constants in shared package led_strip_pkg.
REQ-032 SHALL split the per-bit HIGH/LOW timer into sub-module led_bit_gen (inputs start, bit value; outputs line level, bit_end), with led_strip_tx owning the registers, FSM and latch.

Verification
REQ-033 SHALL cover: LED_COUNT=2, bytes 0x80,0x00,0x00,0x01,0x00,0xFF, start -> 48 bits; bit0 high 40 cycles, bit1 high 15 cycles; every period 62 cycles.
REQ-034 SHALL cover: frame end -> o_sk low 4000 cycles, o_done single pulse at cycle 2976+4000 after first rise, o_busy falls with it.
REQ-035 SHALL cover: write 0x55 to address 0 and a second start while busy -> both ignored; read-back of address 0 is unchanged and the frame is uncorrupted.
REQ-036 SHALL cover: i_rst_n low at bit 10 -> o_sk=0 same cycle; all reads 0 after release; no output until a start write.
REQ-037 SHALL cover: a start write on the o_done cycle -> the next frame's first rising edge 2 cycles later with no missed latch.
REQ-038 SHALL cover: read CTRL during a frame -> 0x01; after o_done -> 0x00; read address 3*LED_COUNT+1 -> 0x00.

Source files
------------

// File: rtl/led_strip_pkg.sv
// Shared FSM encoding and time-to-cycle conversion helpers for the LED strip transmitter.
// Cycle counts truncate toward zero so a bit never runs longer than its nominal time.
package led_strip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    localparam longint NS_PER_S = 64'd1_000_000_000;
    localparam longint US_PER_S = 64'd1_000_000;

    function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns) / NS_PER_S);
    endfunction

    function automatic int us_to_cyc(input longint clk_hz, input longint us);
        return int'((clk_hz * us) / US_PER_S);
    endfunction

endpackage

// File: rtl/led_bit_gen.sv
// One serial bit: line high for T0H/T1H cycles, then low until TBIT cycles from the start.
// o_bit_end warns one cycle early so the owner can place the next start in the final cycle.
module led_bit_gen #(
    parameter int TBIT = 62,
    parameter int T0H  = 15,
    parameter int T1H  = 40
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_bit,
    output logic o_line,
    output logic o_bit_end
);

    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] hi_len;
    logic          active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            hi_len <= '0;
            active <= 1'b0;
            o_line <= 1'b0;
        end else if (i_start) begin
            cnt    <= '0;
            hi_len <= i_bit ? CW'(T1H) : CW'(T0H);
            active <= 1'b1;
            o_line <= 1'b1;
        end else if (active) begin
            if (cnt == CW'(TBIT - 1)) begin
                cnt    <= '0;
                active <= 1'b0;
                o_line <= 1'b0;
            end else begin
                cnt    <= cnt + 1'b1;
                o_line <= (cnt + 1'b1) < hi_len;
            end
        end
    end

    assign o_bit_end = active && (cnt == CW'(TBIT - 2));

endmodule

// File: rtl/led_strip_tx.sv
// Register-mapped LED strip transmitter: colour bytes plus a control register, serialised MSB
// first as fixed-period bits, followed by a low latch gap and a one-cycle done pulse.
module led_strip_tx
    import led_strip_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int LED_COUNT = 8,
    parameter int T0H_NS    = 300,
    parameter int T1H_NS    = 800,
    parameter int TBIT_NS   = 1250,
    parameter int TRST_US   = 80,
    parameter int ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sk
);

    localparam int NBYTES = 3 * LED_COUNT;
    localparam int NBITS  = 24 * LED_COUNT;
    localparam int BW     = $clog2(NBYTES);
    localparam int NW     = $clog2(NBITS + 1);
    localparam int TBIT_C = ns_to_cyc(CLK_HZ, TBIT_NS);
    localparam int T0H_C  = ns_to_cyc(CLK_HZ, T0H_NS);
    localparam int T1H_C  = ns_to_cyc(CLK_HZ, T1H_NS);
    localparam int TRST_C = us_to_cyc(CLK_HZ, TRST_US);
    localparam int LW     = $clog2(TRST_C + 1);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NBYTES);

    state_t                  state, state_d;
    logic [NBYTES-1:0][7:0]  mem;
    logic [BW-1:0]           byte_idx;
    logic [NW-1:0]           bit_cnt;
    logic [2:0]              bit_pos;
    logic [7:0]              shreg;
    logic [7:0]              cur_byte;
    logic                    due;
    logic [LW-1:0]           latch_cnt;
    logic                    done;

    logic wr, busy, is_col, start_wr;
    logic gen_start, gen_bit, gen_line, bit_end;
    logic load_byte, shift;

    assign wr       = !i_wr_n;
    assign busy     = (state != ST_IDLE);
    assign is_col   = (i_addr < CTRL_ADDR);
    assign start_wr = wr && !busy && (i_addr == CTRL_ADDR) && i_data[0];
    assign cur_byte = mem[byte_idx];

    always_comb begin
        if (i_addr == CTRL_ADDR) o_data = {7'b0, busy};
        else if (is_col)         o_data = mem[i_addr[BW-1:0]];
        else                     o_data = 8'h00;
    end

    // LOAD always lands in the final cycle of the previous bit (or straight after the start
    // write), so it fetches the byte and launches its MSB in the same cycle.
    always_comb begin
        state_d   = state;
        gen_start = 1'b0;
        gen_bit   = shreg[7];
        load_byte = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: if (start_wr) state_d = ST_LOAD;
            ST_LOAD: begin
                gen_start = 1'b1;
                gen_bit   = cur_byte[7];
                load_byte = 1'b1;
                state_d   = ST_HIGH;
            end
            ST_HIGH, ST_LOW: begin
                if (due) begin
                    gen_start = 1'b1;
                    shift     = 1'b1;
                    state_d   = ST_HIGH;
                end else if (bit_end) begin
                    if (bit_cnt == NW'(NBITS)) state_d = ST_LATCH;
                    else if (bit_pos == 3'd0)  state_d = ST_LOAD;
                end else if (state == ST_HIGH && !gen_line) begin
                    state_d = ST_LOW;
                end
            end
            ST_LATCH: if (latch_cnt == LW'(TRST_C)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            mem       <= '0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            bit_pos   <= '0;
            shreg     <= '0;
            due       <= 1'b0;
            latch_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_d;
            done  <= (state == ST_LATCH) && (state_d == ST_IDLE);
            due   <= (state == ST_HIGH || state == ST_LOW) && bit_end &&
                     (bit_cnt != NW'(NBITS)) && (bit_pos != 3'd0);
            latch_cnt <= (state == ST_LATCH && state_d == ST_LATCH) ? latch_cnt + 1'b1 : '0;
            if (start_wr) begin
                byte_idx <= '0;
                bit_cnt  <= '0;
            end
            if (load_byte) begin
                shreg    <= {cur_byte[6:0], 1'b0};
                bit_pos  <= 3'd7;
                byte_idx <= byte_idx + 1'b1;
            end
            if (shift) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_pos <= bit_pos - 1'b1;
            end
            if (gen_start) bit_cnt <= bit_cnt + 1'b1;
            // Frame data is frozen while busy so the serialiser never sees a torn byte.
            if (wr && !busy && is_col) mem[i_addr[BW-1:0]] <= i_data;
        end
    end

    led_bit_gen #(
        .TBIT (TBIT_C),
        .T0H  (T0H_C),
        .T1H  (T1H_C)
    ) u_bit_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (gen_start),
        .i_bit     (gen_bit),
        .o_line    (gen_line),
        .o_bit_end (bit_end)
    );

    assign o_busy = busy;
    assign o_done = done;
    assign o_sk   = gen_line;

endmodule

// File: tb/tb_led_strip_tx.sv
// Scoreboard bench for led_strip_tx with two LEDs: stimulus queues expected bit pulses and
// frame-done latencies, a negedge monitor measures the serial line and compares.
module tb_led_strip_tx;

    localparam int LEDS = 2;
    localparam int CTRL = 6;
    localparam int T0H  = 15;
    localparam int T1H  = 40;
    localparam int TBIT = 62;
    localparam int TRST = 4000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_n  = 1'b1;
    logic [7:0] addr  = 8'h00;
    logic [7:0] data  = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, sk;

    led_strip_tx #(
        .CLK_HZ    (50_000_000),
        .LED_COUNT (LEDS),
        .T0H_NS    (300),
        .T1H_NS    (800),
        .TBIT_NS   (1250),
        .TRST_US   (80),
        .ADDR_W    (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wr_n  (wr_n),
        .i_addr  (addr),
        .i_data  (data),
        .o_data  (rdata),
        .o_busy  (busy),
        .o_done  (done),
        .o_sk    (sk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = bit pulse, 1 = frame done
        int a;      // bit: low gap before rise (first bit: cycles from start write); done: cycles from first rise
        int b;      // bit: high length
    } ev_t;

    ev_t        sb[$];
    int         tests = 0;
    int         fails = 0;
    int         start_cyc = 0;
    int         rise_cnt = 0;
    logic [7:0] fb [6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame();
        int   prev_h;
        int   h;
        ev_t  e;
        prev_h = 0;
        for (int i = 0; i < 48; i++) begin
            h      = fb[i / 8][7 - (i % 8)] ? T1H : T0H;
            e.kind = 0;
            e.a    = (i == 0) ? 2 : TBIT - prev_h;
            e.b    = h;
            sb.push_back(e);
            prev_h = h;
        end
        e.kind = 1;
        e.a    = 48 * TBIT + TRST;
        e.b    = 0;
        sb.push_back(e);
    endtask

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        addr = 8'(a); data = 8'(d); wr_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1;
    endtask

    task automatic rd(input int a, output int v);
        addr = 8'(a);
        #1;
        v = int'(rdata);
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        addr = 8'(CTRL); data = 8'h01; wr_n = 1'b0;
        start_cyc = cyc;
        @(posedge clk); #1;
        wr_n = 1'b1;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("done_within_budget", int'(seen), 1);
    endtask

    // Monitor: turns the serial line into bit/done events and checks them against the queue.
    initial begin
        bit   in_frame, prev_sk, prev_done, prev_busy;
        int   rise_c, fall_c, first_c, gap;
        ev_t  e;
        in_frame = 0; prev_sk = 0; prev_done = 0; prev_busy = 0;
        rise_c = 0; fall_c = 0; first_c = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 0;
                prev_sk   = 0;
                prev_done = 0;
                prev_busy = 0;
            end else begin
                if (sk && !prev_sk) begin
                    gap = in_frame ? cyc - fall_c : cyc - start_cyc;
                    if (!in_frame) first_c = cyc;
                    in_frame = 1;
                    rise_c   = cyc;
                    rise_cnt++;
                end
                if (!sk && prev_sk) begin
                    fall_c = cyc;
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_underflow: got bit pulse at cycle %0d, expected no event", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind_bit", 0, e.kind);
                        chk("bit_low_gap", gap, e.a);
                        chk("bit_high_len", cyc - rise_c, e.b);
                    end
                end
                if (done) begin
                    chk("done_single_cycle", int'(prev_done), 0);
                    if (!prev_done) begin
                        if (sb.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL sb_underflow: got done at cycle %0d, expected no event", cyc);
                        end else begin
                            e = sb.pop_front();
                            chk("event_kind_done", 1, e.kind);
                            chk("done_latency", cyc - first_c, e.a);
                        end
                        chk("busy_at_done", int'(busy), 0);
                        chk("busy_before_done", int'(prev_busy), 1);
                        in_frame = 0;
                    end
                end
                prev_sk   = sk;
                prev_done = done;
                prev_busy = busy;
            end
        end
    end

    initial begin
        int v;
        int base;
        int highs;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sk", int'(sk), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rd(CTRL, v); chk("rst_ctrl_read", v, 0);
        rst_n = 1'b1;

        // Frame 1: 0x80,0x00,0x00,0x01,0x00,0xFF
        fb[0] = 8'h80; fb[1] = 8'h00; fb[2] = 8'h00;
        fb[3] = 8'h01; fb[4] = 8'h00; fb[5] = 8'hFF;
        for (int i = 0; i < 6; i++) wr(i, int'(fb[i]));
        rd(0, v); chk("readback_addr0", v, 8'h80);
        rd(5, v); chk("readback_addr5", v, 8'hFF);
        push_frame();
        start_frame();

        // Writes while busy must be ignored
        repeat (100) @(posedge clk);
        wr(0, 8'h55);
        wr(CTRL, 8'h01);
        rd(0, v); chk("busy_write_ignored", v, 8'h80);
        rd(CTRL, v); chk("ctrl_during_frame", v, 8'h01);
        rd(CTRL + 1, v); chk("read_beyond_ctrl", v, 8'h00);

        // Restart on the done cycle itself
        wait_done(8000, seen);
        if (seen) begin
            addr = 8'(CTRL);
            #1;
            chk("ctrl_after_done", int'(rdata), 0);
            data = 8'h01; wr_n = 1'b0;
            start_cyc = cyc;
            push_frame();
            @(posedge clk); #1;
            wr_n = 1'b1;
            chk("busy_after_restart", int'(busy), 1);
        end

        // Reset in the middle of frame 2, during the high phase of bit 10
        base = rise_cnt;
        for (int i = 0; i < 2000 && rise_cnt < base + 11; i++) @(posedge clk);
        chk("reached_bit10", rise_cnt - base, 11);
        repeat (5) @(posedge clk);
        #2;
        chk("sk_high_before_rst", int'(sk), 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midframe_rst_sk", int'(sk), 0);
        chk("midframe_rst_busy", int'(busy), 0);
        chk("midframe_rst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk($sformatf("post_rst_read_%0d", i), v, 0);
        end
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sk || busy) highs++;
        end
        chk("no_autostart", highs, 0);

        // Frame 3: mixed bit patterns
        fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'h0F;
        fb[3] = 8'hF0; fb[4] = 8'hC3; fb[5] = 8'h5A;
        for (int i = 0; i < 6; i++) wr(i, int'(fb[i]));
        rd(2, v); chk("readback_addr2", v, 8'h0F);
        push_frame();
        start_frame();
        wait_done(8000, seen);
        repeat (5) @(posedge clk);
        #1;
        rd(CTRL, v); chk("ctrl_idle_end", v, 0);
        chk("sb_leftover", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
